// File: rtl/chip8_sound_timers.sv
// chip8_sound_timers
// CHIP-8 delay (DT) and sound (ST) timers with a 60 Hz prescaler.
// The prescaler divides clk_in by DIV = CLK_HZ / TICK_HZ. Each tick
// decrements both timers toward zero.
// Optional feature macro: CHIP8_ST_MIN2_EN. When it is defined, an ST load
// of 1 is turned into 0, which matches the COSMAC VIP behaviour where one
// tick of sound is inaudible.
module chip8_sound_timers #(
  parameter int CLK_HZ  = 74_250_000,
  parameter int TICK_HZ = 60
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       pause_in,
  input  logic       dt_we_in,
  input  logic       st_we_in,
  input  logic [7:0] wdata_in,
  output logic [7:0] dt_out,
  output logic [7:0] st_out,
  output logic       tick_out,
  output logic       sound_active_out
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  // A divider of 0 or 1 leaves no room for a prescaler, so refuse to build.
  generate
    if (DIV < 2) begin : g_bad_div
      $error("chip8_sound_timers: CLK_HZ / TICK_HZ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_dt;
  logic [7:0]    r_st;
  logic          r_tick;
  logic          r_sound;

  logic          w_tick;
  logic [7:0]    w_st_load;
  logic [7:0]    w_dt_next;
  logic [7:0]    w_st_next;

  // A tick fires on the last prescaler count, but only while the emulator runs.
  assign w_tick = (r_cnt == LAST_CNT) && !pause_in;

`ifdef CHIP8_ST_MIN2_EN
  // A sound load of 1 is squashed to 0 so that no sound is produced.
  assign w_st_load = (wdata_in == 8'd1) ? 8'd0 : wdata_in;
`else
  // Sound loads are taken verbatim.
  assign w_st_load = wdata_in;
`endif

  // Next timer values: a write always wins; otherwise decrement on a tick,
  // and saturate at zero.
  always_comb begin
    w_dt_next = r_dt;
    w_st_next = r_st;
    if (dt_we_in) begin
      w_dt_next = wdata_in;
    end else if (w_tick && (r_dt != 8'd0)) begin
      w_dt_next = r_dt - 8'd1;
    end
    if (st_we_in) begin
      w_st_next = w_st_load;
    end else if (w_tick && (r_st != 8'd0)) begin
      w_st_next = r_st - 8'd1;
    end
  end

  // Prescaler: wraps at DIV-1 and holds its count while paused.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (!pause_in) begin
      if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // One-cycle tick pulse, plus timer and sound-flag registers. The sound flag
  // follows the next ST value so it moves on the same edge as st_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick  <= 1'b0;
      r_dt    <= 8'd0;
      r_st    <= 8'd0;
      r_sound <= 1'b0;
    end else begin
      r_tick  <= w_tick;
      r_dt    <= w_dt_next;
      r_st    <= w_st_next;
      r_sound <= (w_st_next != 8'd0);
    end
  end

  assign dt_out           = r_dt;
  assign st_out           = r_st;
  assign tick_out         = r_tick;
  assign sound_active_out = r_sound;

endmodule

// File: tb/tb_chip8_sound_timers.sv
// Testbench for chip8_sound_timers with DIV = 10 (600 Hz clock, 60 Hz tick).
module tb_chip8_sound_timers;

  localparam int DIV = 10;

  logic       clk;
  logic       rstN;
  logic       pause;
  logic       dtWe;
  logic       stWe;
  logic [7:0] wdata;
  logic [7:0] dtOut;
  logic [7:0] stOut;
  logic       tickOut;
  logic       soundOut;

  int checks;
  int failures;

  // Reference model state: count of unpaused edges since reset and timer values.
  int  mEdges;
  int  mDt;
  int  mSt;
  bit  mTick;

  typedef struct {
    int         cyc;
    logic       dwe;
    logic       swe;
    logic [7:0] wd;
    int         expDt;
    int         expSt;
    int         expTick;
    int         expSnd;
  } vec_t;

  vec_t vecs[14];

  chip8_sound_timers #(
    .CLK_HZ (600),
    .TICK_HZ(60)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rstN),
    .pause_in        (pause),
    .dt_we_in        (dtWe),
    .st_we_in        (stWe),
    .wdata_in        (wdata),
    .dt_out          (dtOut),
    .st_out          (stOut),
    .tick_out        (tickOut),
    .sound_active_out(soundOut)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int stLoadValue(input int v);
`ifdef CHIP8_ST_MIN2_EN
    return (v == 1) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input int eDt, input int eSt, input int eTick, input int eSnd);
    checkOutput({tag, ".dt"}, int'(dtOut), eDt);
    checkOutput({tag, ".st"}, int'(stOut), eSt);
    checkOutput({tag, ".tick"}, int'(tickOut), eTick);
    checkOutput({tag, ".snd"}, int'(soundOut), eSnd);
  endtask

  task automatic modelReset();
    mEdges = 0;
    mDt    = 0;
    mSt    = 0;
    mTick  = 0;
  endtask

  // Drive one cycle of inputs, wait for the edge that samples them, and
  // advance the reference model by the same edge.
  task automatic applyStimulus(input logic p, input logic dwe, input logic swe, input logic [7:0] wd);
    pause = p;
    dtWe  = dwe;
    stWe  = swe;
    wdata = wd;
    @(posedge clk);
    #1;
    if (!p) begin
      mEdges++;
      mTick = ((mEdges % DIV) == 0);
    end else begin
      mTick = 0;
    end
    if (dwe) mDt = int'(wd);
    else if (mTick && mDt > 0) mDt = mDt - 1;
    if (swe) mSt = stLoadValue(int'(wd));
    else if (mTick && mSt > 0) mSt = mSt - 1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  initial begin
    int vi;
    int found;
    logic dwe;
    logic swe;
    logic [7:0] wd;

    checks   = 0;
    failures = 0;
    rstN  = 1'b0;
    pause = 1'b0;
    dtWe  = 1'b0;
    stWe  = 1'b0;
    wdata = 8'd0;
    modelReset();

    vecs[0]  = '{2,  1'b1, 1'b0, 8'd3, 3, 0, 0, 0};
    vecs[1]  = '{5,  1'b0, 1'b1, 8'd2, 3, 2, 0, 1};
    vecs[2]  = '{9,  1'b0, 1'b0, 8'd0, 3, 2, 0, 1};
    vecs[3]  = '{10, 1'b0, 1'b0, 8'd0, 2, 1, 1, 1};
    vecs[4]  = '{11, 1'b0, 1'b0, 8'd0, 2, 1, 0, 1};
    vecs[5]  = '{20, 1'b0, 1'b0, 8'd0, 1, 0, 1, 0};
    vecs[6]  = '{30, 1'b0, 1'b0, 8'd0, 0, 0, 1, 0};
    vecs[7]  = '{40, 1'b0, 1'b0, 8'd0, 0, 0, 1, 0};
    vecs[8]  = '{41, 1'b0, 1'b0, 8'd0, 0, 0, 0, 0};
    vecs[9]  = '{42, 1'b1, 1'b0, 8'd4, 4, 0, 0, 0};
    vecs[10] = '{50, 1'b1, 1'b0, 8'd9, 9, 0, 1, 0};
    vecs[11] = '{60, 1'b0, 1'b0, 8'd0, 8, 0, 1, 0};
    vecs[12] = '{61, 1'b1, 1'b1, 8'd7, 7, 7, 0, 1};
    vecs[13] = '{70, 1'b0, 1'b0, 8'd0, 6, 6, 1, 1};

    // Reset state with the clock running.
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0);
    releaseReset();

    // Table scenario: DT/ST countdown, saturation, write-in-tick-cycle, dual write.
    vi = 0;
    for (int c = 1; c <= 70; c++) begin
      dwe = 1'b0;
      swe = 1'b0;
      wd  = 8'd0;
      if (vi < 14 && vecs[vi].cyc == c) begin
        dwe = vecs[vi].dwe;
        swe = vecs[vi].swe;
        wd  = vecs[vi].wd;
      end
      applyStimulus(1'b0, dwe, swe, wd);
      if (vi < 14 && vecs[vi].cyc == c) begin
        checkAll($sformatf("vec%0d", vi), vecs[vi].expDt, vecs[vi].expSt,
                 vecs[vi].expTick, vecs[vi].expSnd);
        vi++;
      end
    end

    // Pause: DT=4, freeze at cnt=6 for 25 cycles, ST=5 written while paused.
    rstN = 1'b0;
    #2;
    releaseReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd4);
    for (int c = 2; c <= 6; c++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int c = 7; c <= 31; c++) begin
      if (c == 15) applyStimulus(1'b1, 1'b0, 1'b1, 8'd5);
      else applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
      checkOutput("pause.tick", int'(tickOut), 0);
      checkOutput("pause.dt", int'(dtOut), 4);
      if (c == 15) checkOutput("pause.stWrite", int'(stOut), 5);
    end
    for (int c = 32; c <= 34; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      checkOutput("resume.noTick", int'(tickOut), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkAll("resume.tick", 3, 4, 1, 1);

    // Reset asserted while tick_out is high clears everything at once.
    rstN = 1'b0;
    #1;
    checkAll("midPulseReset", 0, 0, 0, 0);
    releaseReset();

    // Reset asserted mid-count, with sound on; next tick is DIV edges after release.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkAll("midCountReset", 0, 0, 0, 0);
    releaseReset();
    found = -1;
    for (int n = 1; n <= 30; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      if (tickOut) begin
        found = n;
        break;
      end
    end
    checkOutput("tickAfterRelease", found, DIV);

    // ST = 1 load.
    rstN = 1'b0;
    #2;
    releaseReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd1);
`ifdef CHIP8_ST_MIN2_EN
    checkOutput("st1.st", int'(stOut), 0);
    checkOutput("st1.snd", int'(soundOut), 0);
`else
    checkOutput("st1.st", int'(stOut), 1);
    checkOutput("st1.snd", int'(soundOut), 1);
`endif
    for (int k = 2; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
`ifdef CHIP8_ST_MIN2_EN
      checkOutput("st1.sndHold", int'(soundOut), 0);
`else
      checkOutput("st1.sndHold", int'(soundOut), (k < DIV) ? 1 : 0);
`endif
    end

    // Randomized traffic against the reference model.
    rstN = 1'b0;
    #2;
    releaseReset();
    for (int n = 0; n < 3000; n++) begin
      logic p;
      p   = ($urandom_range(0, 9) < 2);
      dwe = ($urandom_range(0, 19) == 0);
      swe = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) wd = 8'($urandom_range(0, 2));
      else wd = 8'($urandom_range(0, 255));
      applyStimulus(p, dwe, swe, wd);
      checkOutput("rand.dt", int'(dtOut), mDt);
      checkOutput("rand.st", int'(stOut), mSt);
      checkOutput("rand.tick", int'(tickOut), int'(mTick));
      checkOutput("rand.snd", int'(soundOut), (mSt != 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
